cu_read_cmd_generator: RTL and testbench

Read-command generator for a compute unit (CU). It takes one array-fetch request: a base address, an element count and a CU ID. It splits the byte range into a sequence of naturally aligned, power-of-two-sized read commands of at most 128 B, and presents them one at a time on a valid/ready interface. Downstream, the command buffer issues them to the PSL. The resulting read responses come back as DataRead beats.

---
 rtl/cu_read_cmd_generator.sv | 234 +++++++++++++++++++++++
 tb/tb_cu_read_cmd_generator.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_read_cmd_generator.sv
`default_nettype none
// ============================================================================
// Module   : cu_read_cmd_generator
// Brief    : Splits one array-fetch request (base address, element count,
//            CU ID) into naturally aligned, power-of-two read commands of at
//            most MAX_CMD_BYTES and presents them one at a time on a
//            valid/ready command port.
// Options  : CU_READ_CMD_CREDIT_EN - adds the rsp_done input and limits the
//            number of accepted-but-unretired commands to MAX_OUTSTANDING.
// Revision : 1.0 - initial release
// ============================================================================
module cu_read_cmd_generator #(
  parameter int ARRAY_SIZE      = 4,
  parameter int ADDR_WIDTH      = 64,
  parameter int COUNT_WIDTH     = 32,
  parameter int CU_ID_WIDTH     = 8,
  parameter int MAX_CMD_BYTES   = 128,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                   clock,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] num_elements,
  input  logic [CU_ID_WIDTH-1:0] cu_id_in,
  input  logic                   cmd_ready,
`ifdef CU_READ_CMD_CREDIT_EN
  input  logic                   rsp_done,
`endif
  output logic                   cmd_valid,
  output logic [ADDR_WIDTH-1:0]  cmd_address,
  output logic [11:0]            cmd_size,
  output logic [CU_ID_WIDTH-1:0] cmd_cu_id,
  output logic [7:0]             cmd_tag,
  output logic                   cmd_last,
  output logic                   busy,
  output logic                   done
);

  // Element size as a shift amount; remaining-bytes width leaves room for
  // the largest element shift (ARRAY_SIZE <= 128).
  localparam int C_ASIZE_LOG2 = $clog2(ARRAY_SIZE);
  localparam int C_MAX_LOG2   = $clog2(MAX_CMD_BYTES);
  localparam int C_REM_W      = COUNT_WIDTH + 7;
  localparam logic [ADDR_WIDTH-1:0] C_ELEM_MASK =
    ~((ADDR_WIDTH)'(ARRAY_SIZE) - (ADDR_WIDTH)'(1));

  // Reject configurations the size rule cannot honour.
  if ((ARRAY_SIZE < 1) || (ARRAY_SIZE > 128) || ((ARRAY_SIZE & (ARRAY_SIZE - 1)) != 0) ||
      (MAX_CMD_BYTES < ARRAY_SIZE) || (MAX_CMD_BYTES > 128) ||
      (MAX_OUTSTANDING < 1) || (ADDR_WIDTH < 8) || (COUNT_WIDTH < 12)) begin : g_bad_params
    $error("cu_read_cmd_generator: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Registered state and outputs
  state_e                 state_q,       state_d;
  logic [ADDR_WIDTH-1:0]  cur_addr_q,    cur_addr_d;
  logic [COUNT_WIDTH-1:0] remaining_q,   remaining_d;
  logic [CU_ID_WIDTH-1:0] cu_id_q,       cu_id_d;
  logic                   cmd_valid_q,   cmd_valid_d;
  logic [ADDR_WIDTH-1:0]  cmd_address_q, cmd_address_d;
  logic [11:0]            cmd_size_q,    cmd_size_d;
  logic                   cmd_last_q,    cmd_last_d;
  logic [7:0]             cmd_tag_q,     cmd_tag_d;
  logic                   busy_q,        busy_d;
  logic                   done_q,        done_d;

  // Combinational helpers
  logic [C_REM_W-1:0]     w_rem_bytes;
  logic [C_REM_W-1:0]     w_pow;
  logic                   w_aligned;
  logic [11:0]            w_size;
  logic [11:0]            w_size_elems;
  logic                   w_accept;
  logic                   w_load;
  logic                   w_credit_ok;
  logic                   w_out_zero;

`ifdef CU_READ_CMD_CREDIT_EN
  localparam int C_OUT_W = $clog2(MAX_OUTSTANDING + 1);
  logic [C_OUT_W-1:0]     outstanding_q, outstanding_d;
  logic                   w_rsp_dec;
`endif

  assign w_rem_bytes  = C_REM_W'(remaining_q) << C_ASIZE_LOG2;
  assign w_size_elems = w_size >> C_ASIZE_LOG2;
  assign w_accept     = cmd_valid_q & cmd_ready;

  // Largest power of two that fits the remaining bytes, the command cap and
  // the alignment of cur_addr; alignment is accumulated bit by bit.
  always_comb begin
    w_size    = '0;
    w_pow     = '0;
    w_aligned = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      w_pow = C_REM_W'(1) << k;
      if (w_aligned && (k <= C_MAX_LOG2) && (w_rem_bytes >= w_pow)) begin
        w_size = 12'(w_pow);
      end
      w_aligned = w_aligned & ~cur_addr_q[k];
    end
  end

  // Credit accounting: an acceptance and a retirement in the same cycle cancel.
`ifdef CU_READ_CMD_CREDIT_EN
  always_comb begin
    w_rsp_dec     = rsp_done && (outstanding_q != '0);
    outstanding_d = outstanding_q;
    if (w_accept && !w_rsp_dec) begin
      outstanding_d = outstanding_q + C_OUT_W'(1);
    end else if (!w_accept && w_rsp_dec) begin
      outstanding_d = outstanding_q - C_OUT_W'(1);
    end
    w_credit_ok = ((C_OUT_W + 1)'(outstanding_q) + (C_OUT_W + 1)'(cmd_valid_q))
                  < (C_OUT_W + 1)'(MAX_OUTSTANDING);
    w_out_zero  = (outstanding_d == '0);
  end
`else
  assign w_credit_ok = 1'b1;
  assign w_out_zero  = 1'b1;
`endif

  // A new command may load when the slot is empty or being emptied this cycle.
  assign w_load = (state_q == S_RUN) && (remaining_q != '0) && enable && w_credit_ok &&
                  (!cmd_valid_q || w_accept);

  // Next-state computation for the FSM, command slot and tag counter.
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    cu_id_d       = cu_id_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_address_d = cmd_address_q;
    cmd_size_d    = cmd_size_q;
    cmd_last_d    = cmd_last_q;
    cmd_tag_d     = cmd_tag_q;

    if (w_accept) begin
      cmd_valid_d = 1'b0;
      cmd_tag_d   = cmd_tag_q + 8'd1;
    end

    if (w_load) begin
      cmd_valid_d   = 1'b1;
      cmd_address_d = cur_addr_q;
      cmd_size_d    = w_size;
      cmd_last_d    = (C_REM_W'(w_size) == w_rem_bytes);
      cur_addr_d    = cur_addr_q + ADDR_WIDTH'(w_size);
      remaining_d   = remaining_q - COUNT_WIDTH'(w_size_elems);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          cur_addr_d  = base_addr & C_ELEM_MASK;
          remaining_d = num_elements;
          cu_id_d     = cu_id_in;
        end
      end
      S_RUN: begin
        // Leave as soon as the slot will be empty after this edge, so done
        // follows the final acceptance by exactly one cycle.
        if ((remaining_q == '0) && !cmd_valid_d && w_out_zero) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // All state and outputs registered; asynchronous clear on rstn.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      cu_id_q       <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_address_q <= '0;
      cmd_size_q    <= '0;
      cmd_last_q    <= 1'b0;
      cmd_tag_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef CU_READ_CMD_CREDIT_EN
      outstanding_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      cu_id_q       <= cu_id_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_address_q <= cmd_address_d;
      cmd_size_q    <= cmd_size_d;
      cmd_last_q    <= cmd_last_d;
      cmd_tag_q     <= cmd_tag_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef CU_READ_CMD_CREDIT_EN
      outstanding_q <= outstanding_d;
`endif
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_address = cmd_address_q;
  assign cmd_size    = cmd_size_q;
  assign cmd_cu_id   = cu_id_q;
  assign cmd_tag     = cmd_tag_q;
  assign cmd_last    = cmd_last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cu_read_cmd_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cu_read_cmd_generator
// Brief    : Scoreboard bench for cu_read_cmd_generator (ARRAY_SIZE = 4).
//            Expected commands are queued when a request is started and
//            compared as the DUT's commands are accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cu_read_cmd_generator;

  localparam int AW = 64;
  localparam int CW = 32;
  localparam int IW = 8;
`ifdef CU_READ_CMD_CREDIT_EN
  localparam int TB_MAX_OUT = 2;
`else
  localparam int TB_MAX_OUT = 16;
`endif

  logic          clock = 1'b0;
  logic          rstn  = 1'b1;
  logic          enable = 1'b0;
  logic          start  = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_elements = '0;
  logic [IW-1:0] cu_id_in = '0;
  logic          cmd_ready = 1'b0;
`ifdef CU_READ_CMD_CREDIT_EN
  logic          rsp_done = 1'b0;
`endif
  logic          cmd_valid;
  logic [AW-1:0] cmd_address;
  logic [11:0]   cmd_size;
  logic [IW-1:0] cmd_cu_id;
  logic [7:0]    cmd_tag;
  logic          cmd_last;
  logic          busy;
  logic          done;

  cu_read_cmd_generator #(
    .ARRAY_SIZE      (4),
    .ADDR_WIDTH      (AW),
    .COUNT_WIDTH     (CW),
    .CU_ID_WIDTH     (IW),
    .MAX_CMD_BYTES   (128),
    .MAX_OUTSTANDING (TB_MAX_OUT)
  ) dut (
    .clock        (clock),
    .rstn         (rstn),
    .enable       (enable),
    .start        (start),
    .base_addr    (base_addr),
    .num_elements (num_elements),
    .cu_id_in     (cu_id_in),
    .cmd_ready    (cmd_ready),
`ifdef CU_READ_CMD_CREDIT_EN
    .rsp_done     (rsp_done),
`endif
    .cmd_valid    (cmd_valid),
    .cmd_address  (cmd_address),
    .cmd_size     (cmd_size),
    .cmd_cu_id    (cmd_cu_id),
    .cmd_tag      (cmd_tag),
    .cmd_last     (cmd_last),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [63:0] addr;
    logic [11:0] size;
    logic [7:0]  tag;
    logic        last;
    logic [7:0]  cu;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  exp_t       stall_pl;
  logic       stall_prev = 1'b0;
  logic [7:0] exp_tag = 8'd0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_acc_cyc = -10;
  int         n_acc = 0;
  bit         chk_done_lat = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference split: start from the largest size and halve until it fits.
  task automatic push_req(input logic [63:0] base, input int num, input logic [7:0] cu);
    logic [63:0] addr;
    longint      rem;
    longint      p;
    addr = base & ~64'd3;
    rem  = longint'(num) * 4;
    while (rem > 0) begin
      p = 128;
      while ((p > rem) || ((addr % p) != 0)) p = p / 2;
      exp_q.push_back('{addr, 12'(p), exp_tag, (p == rem), cu});
      exp_tag = exp_tag + 8'd1;
      addr    = addr + 64'(p);
      rem     = rem - p;
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [63:0] base, input int num, input logic [7:0] cu);
    push_req(base, num, cu);
    base_addr    = base;
    num_elements = CW'(num);
    cu_id_in     = cu;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((done !== 1'b1) && (k < budget)) begin
      @(negedge clock);
      k++;
    end
    chk_eq("done_seen", done, 1);
    tick();
    chk_eq("idle_after_done", busy, 0);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    @(negedge clock);
    while ((cmd_valid !== 1'b1) && (k < budget)) begin
      @(negedge clock);
      k++;
    end
    chk_eq("valid_seen", cmd_valid, 1);
  endtask

  // Monitor: stability under stall, scoreboard on acceptance, done timing.
  always @(negedge clock) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk_eq("stall_valid", cmd_valid, 1);
        chk_eq("stall_addr", cmd_address, stall_pl.addr);
        chk_eq("stall_size", cmd_size, stall_pl.size);
        chk_eq("stall_tag", cmd_tag, stall_pl.tag);
        chk_eq("stall_last", cmd_last, stall_pl.last);
      end
      stall_prev = cmd_valid && !cmd_ready;
      if (stall_prev) stall_pl = '{cmd_address, cmd_size, cmd_tag, cmd_last, cmd_cu_id};
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_cmd", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk_eq("cmd_addr", cmd_address, mon_e.addr);
          chk_eq("cmd_size", cmd_size, mon_e.size);
          chk_eq("cmd_tag", cmd_tag, mon_e.tag);
          chk_eq("cmd_last", cmd_last, mon_e.last);
          chk_eq("cmd_cu_id", cmd_cu_id, mon_e.cu);
        end
        n_acc++;
        last_acc_cyc = cyc;
      end
      if (done) begin
        chk_eq("done_sb_empty", exp_q.size(), 0);
        if (chk_done_lat) chk_eq("done_latency", cyc - last_acc_cyc, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    #2 rstn = 1'b0;
    enable  = 1'b1;
    repeat (3) @(negedge clock);
    chk_eq("rst_valid", cmd_valid, 0);
    chk_eq("rst_addr", cmd_address, 0);
    chk_eq("rst_size", cmd_size, 0);
    chk_eq("rst_tag", cmd_tag, 0);
    chk_eq("rst_last", cmd_last, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    @(posedge clock);
    #1 rstn = 1'b1;
    tick();

`ifdef CU_READ_CMD_CREDIT_EN
    // Credit limit of 2 with four 128 B commands.
    chk_done_lat = 1'b0;
    cmd_ready    = 1'b1;
    rsp_done     = 1'b1;          // ignored: nothing outstanding
    tick();
    rsp_done     = 1'b0;
    acc0 = n_acc;
    pulse_start(64'h0, 128, 8'h66);
    repeat (10) tick();
    chk_eq("credit_two_acc", n_acc - acc0, 2);
    @(negedge clock);
    chk_eq("credit_valid_low", cmd_valid, 0);
    chk_eq("credit_busy", busy, 1);
    tick();
    rsp_done = 1'b1;
    tick();
    rsp_done = 1'b0;
    wait_valid(10);
    rsp_done = 1'b1;              // coincides with this acceptance
    tick();
    rsp_done = 1'b0;
    repeat (6) tick();
    chk_eq("credit_four_acc", n_acc - acc0, 4);
    chk_eq("credit_no_done_a", done, 0);
    rsp_done = 1'b1;
    tick();
    rsp_done = 1'b0;
    tick();
    chk_eq("credit_no_done_b", done, 0);
    chk_eq("credit_busy_b", busy, 1);
    rsp_done = 1'b1;
    tick();
    rsp_done = 1'b0;
    wait_done(5);
`else
    // Two full 128 B commands; first valid two cycles after start.
    cmd_ready    = 1'b1;
    chk_done_lat = 1'b1;
    pulse_start(64'h1000, 64, 8'h5A);
    @(negedge clock);
    chk_eq("lat_n1_valid", cmd_valid, 0);
    chk_eq("lat_n1_busy", busy, 1);
    @(negedge clock);
    chk_eq("lat_n2_valid", cmd_valid, 1);
    wait_done(20);

    // Unaligned start, short tail.
    pulse_start(64'h1004, 5, 8'h11);
    wait_done(20);

    // Zero elements: no command, done two cycles after start.
    chk_done_lat = 1'b0;
    pulse_start(64'h3000, 0, 8'h77);
    @(negedge clock);
    chk_eq("zero_busy_n1", busy, 1);
    chk_eq("zero_done_n1", done, 0);
    chk_eq("zero_valid_n1", cmd_valid, 0);
    @(negedge clock);
    chk_eq("zero_busy_n2", busy, 1);
    chk_eq("zero_done_n2", done, 1);
    chk_eq("zero_valid_n2", cmd_valid, 0);
    @(negedge clock);
    chk_eq("zero_busy_n3", busy, 0);
    chk_eq("zero_done_n3", done, 0);
    tick();
    chk_done_lat = 1'b1;

    // Backpressure with an ignored start mid-stall, then enable gating.
    cmd_ready = 1'b0;
    pulse_start(64'h2000, 96, 8'h22);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        base_addr    = 64'h9000;
        num_elements = 32'd7;
        start        = 1'b1;
      end
      if (i == 3) start = 1'b0;
      tick();
    end
    @(negedge clock);
    chk_eq("bp_valid", cmd_valid, 1);
    chk_eq("bp_addr", cmd_address, 64'h2000);
    chk_eq("bp_size", cmd_size, 128);
    chk_eq("bp_tag", cmd_tag, exp_q[0].tag);
    tick();
    cmd_ready = 1'b1;
    enable    = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk_eq("en_hold_valid", cmd_valid, 0);
    end
    tick();
    enable = 1'b1;
    wait_done(20);

    // 300 commands: tags wrap through 255 -> 0.
    pulse_start(64'h0, 9600, 8'h33);
    wait_done(400);

    // Reset mid-request.
    pulse_start(64'h4000, 1000, 8'h44);
    repeat (10) tick();
    #2 rstn = 1'b0;
    #1;
    chk_eq("mrst_valid", cmd_valid, 0);
    chk_eq("mrst_addr", cmd_address, 0);
    chk_eq("mrst_size", cmd_size, 0);
    chk_eq("mrst_tag", cmd_tag, 0);
    chk_eq("mrst_last", cmd_last, 0);
    chk_eq("mrst_cu", cmd_cu_id, 0);
    chk_eq("mrst_busy", busy, 0);
    chk_eq("mrst_done", done, 0);
    exp_q.delete();
    exp_tag = 8'd0;
    @(posedge clock);
    #1 rstn = 1'b1;
    tick();
    pulse_start(64'h100, 8, 8'h55);
    wait_done(20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
